mascota_fsm_niveles: RTL and testbench

- Parametrised successor of the pet mood state machine.
- Owns N_NEEDS internal need levels instead of taking them as inputs. Higher level = worse.
- Levels decay over time via an internal prescaler. Player actions relieve one need per command.
- Derives the registered mood state, with sticky death, death hysteresis and a gated manual test mode. Drives the display/sprite selector.

---
 rtl/mascota_fsm_niveles_if.sv | 30 +++
 rtl/mascota_fsm_niveles.sv | 177 +++++++++++++++++
 tb/tb_mascota_fsm_niveles.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mascota_fsm_niveles_if.sv
// Purpose : groups the pet state machine's action/test inputs and level/mood outputs.
// Latency : n/a (wires only).
// Backpressure: none; every strobe is taken on the cycle it is presented.
// Ports   : master drives accion_valid/accion_id/modo_test/test and observes
//           niveles/estado_actual/estado_cambio/muerto; slave is the opposite side.
interface mascota_fsm_niveles_if #(
   parameter int N_NEEDS = 3,
   parameter int LEVEL_W = 3
);
   localparam int ID_W = (N_NEEDS > 1) ? $clog2(N_NEEDS) : 1;

   logic                       accion_valid;
   logic [ID_W-1:0]            accion_id;
   logic                       modo_test;
   logic                       test;
   logic [N_NEEDS*LEVEL_W-1:0] niveles;
   logic [2:0]                 estado_actual;
   logic                       estado_cambio;
   logic                       muerto;

   modport master (
      output accion_valid, accion_id, modo_test, test,
      input  niveles, estado_actual, estado_cambio, muerto
   );

   modport slave (
      input  accion_valid, accion_id, modo_test, test,
      output niveles, estado_actual, estado_cambio, muerto
   );
endinterface

// File: rtl/mascota_fsm_niveles.sv
// Purpose : pet mood FSM owning N_NEEDS decaying need levels, sticky death and a manual test mode.
// Latency : levels update on the action/tick edge; estado_actual follows one edge later.
// Backpressure: none; an action is applied on the cycle its strobe is high.
// Ports   : clk, reset (sync, active-high); bus.slave carries accion_valid/accion_id,
//           modo_test, test (in) and niveles, estado_actual, estado_cambio, muerto (out).
module mascota_fsm_niveles #(
   parameter int N_NEEDS      = 3,
   parameter int LEVEL_W      = 3,
   parameter int LEVEL_MAX    = 5,
   parameter int INIT_LEVEL   = 2,
   parameter int HIGH_TH      = 4,
   parameter int LOW_TH       = 1,
   parameter int DECAY_CYCLES = 50000000,
   parameter int ACTION_STEP  = 2,
   parameter int DEATH_TICKS  = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   mascota_fsm_niveles_if.slave   bus
);

   typedef enum logic [2:0] {
      NEUTRO     = 3'd0,
      FELIZ      = 3'd1,
      TRISTE     = 3'd2,
      CANSADO    = 3'd3,
      HAMBRIENTO = 3'd4,
      MUERTO     = 3'd5
   } estado_t;

   localparam int ID_W  = (N_NEEDS > 1) ? $clog2(N_NEEDS) : 1;
   localparam int CNT_W = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
   localparam int DTH_W = $clog2(DEATH_TICKS + 1);

   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DECAY_CYCLES - 1);
   localparam logic [DTH_W-1:0]   DTH_FULL = DTH_W'(DEATH_TICKS);
   localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(LEVEL_MAX);
   localparam logic [LEVEL_W-1:0] LVL_INIT = LEVEL_W'(INIT_LEVEL);
   localparam logic [LEVEL_W-1:0] LVL_HI   = LEVEL_W'(HIGH_TH);
   localparam logic [LEVEL_W-1:0] LVL_LO   = LEVEL_W'(LOW_TH);

   // Decay saturates first, then the action is subtracted with a floor at zero,
   // so a tick and an action on the same cycle never wrap.
   function automatic logic [LEVEL_W-1:0] upd_level(
      input logic [LEVEL_W-1:0] lvl,
      input logic               dec,
      input logic               act
   );
      int s;
      s = int'(lvl) + (dec ? 1 : 0);
      if (s > LEVEL_MAX) s = LEVEL_MAX;
      if (act) s = s - ACTION_STEP;
      if (s < 0) s = 0;
      return LEVEL_W'(s);
   endfunction

   logic [LEVEL_W-1:0] lvl_q [N_NEEDS];
   logic [LEVEL_W-1:0] lvl_d [N_NEEDS];
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DTH_W-1:0]   dth_q, dth_d;
   logic               muerto_q, muerto_d;
   logic               test_prev_q, test_prev_d;
   estado_t            estado_q, estado_d;
   logic               cambio_q, cambio_d;

   logic               freeze;
   logic               tick;
   logic               act_ok;
   logic               any_max;
   logic               all_low;
   logic               test_edge;
   estado_t            mood;
   estado_t            step_next;
   logic [N_NEEDS*LEVEL_W-1:0] niveles_w;

   // Prescaler and level/death datapath.
   always_comb begin
      freeze   = bus.modo_test || muerto_q;
      cnt_d    = cnt_q;
      tick     = 1'b0;
      if (!freeze) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      act_ok  = bus.accion_valid && !muerto_q && !bus.modo_test;
      lvl_d   = lvl_q;
      any_max = 1'b0;
      for (int i = 0; i < N_NEEDS; i++) begin
         // Ids >= N_NEEDS match no channel and are dropped here.
         if (!muerto_q)
            lvl_d[i] = upd_level(lvl_q[i], tick, act_ok && (bus.accion_id == ID_W'(i)));
         if (lvl_d[i] == LVL_MAX) any_max = 1'b1;
      end

      dth_d    = dth_q;
      muerto_d = muerto_q;
      if (tick) begin
         if (!any_max) begin
            dth_d = '0;
         end else if (dth_q != DTH_FULL) begin
            dth_d = dth_q + 1'b1;
            if (dth_d == DTH_FULL) muerto_d = 1'b1;
         end
      end
   end

   // Mood decode and display state.
   always_comb begin
      all_low = 1'b1;
      for (int i = 0; i < N_NEEDS; i++)
         if (lvl_q[i] > LVL_LO) all_low = 1'b0;

      mood = NEUTRO;
      if (muerto_q)                mood = MUERTO;
      else if (lvl_q[0] >= LVL_HI) mood = HAMBRIENTO;
      else if (lvl_q[2] >= LVL_HI) mood = CANSADO;
      else if (lvl_q[1] >= LVL_HI) mood = TRISTE;
      else if (all_low)            mood = FELIZ;

      case (estado_q)
         NEUTRO:     step_next = FELIZ;
         FELIZ:      step_next = TRISTE;
         TRISTE:     step_next = CANSADO;
         CANSADO:    step_next = HAMBRIENTO;
         HAMBRIENTO: step_next = MUERTO;
         default:    step_next = NEUTRO;
      endcase

      test_prev_d = bus.test;
      test_edge   = bus.test && !test_prev_q;

      // In test mode the display only moves on a button edge; the real mood
      // (including muerto) keeps being tracked underneath and reappears on exit.
      estado_d = mood;
      if (bus.modo_test)
         estado_d = test_edge ? step_next : estado_q;

      cambio_d = (estado_d != estado_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_NEEDS; i++) lvl_q[i] <= LVL_INIT;
         cnt_q       <= '0;
         dth_q       <= '0;
         muerto_q    <= 1'b0;
         test_prev_q <= 1'b0;
         estado_q    <= NEUTRO;
         cambio_q    <= 1'b0;
      end else begin
         lvl_q       <= lvl_d;
         cnt_q       <= cnt_d;
         dth_q       <= dth_d;
         muerto_q    <= muerto_d;
         test_prev_q <= test_prev_d;
         estado_q    <= estado_d;
         cambio_q    <= cambio_d;
      end
   end

   always_comb begin
      niveles_w = '0;
      for (int i = 0; i < N_NEEDS; i++)
         niveles_w[i*LEVEL_W +: LEVEL_W] = lvl_q[i];
   end

   assign bus.niveles       = niveles_w;
   assign bus.estado_actual = estado_q;
   assign bus.estado_cambio = cambio_q;
   assign bus.muerto        = muerto_q;

endmodule

// File: tb/tb_mascota_fsm_niveles.sv
// Directed bench for mascota_fsm_niveles with DECAY_CYCLES=4, DEATH_TICKS=2.
// Inputs are driven and outputs sampled on the falling edge; after the reset
// edge the prescaler is at 0, so decay ticks land on rising edges 4, 8, 12, ...
module tb_mascota_fsm_niveles;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   mascota_fsm_niveles_if #(.N_NEEDS(3), .LEVEL_W(3)) bus ();

   mascota_fsm_niveles #(
      .N_NEEDS(3), .LEVEL_W(3), .LEVEL_MAX(5), .INIT_LEVEL(2), .HIGH_TH(4),
      .LOW_TH(1), .DECAY_CYCLES(4), .ACTION_STEP(2), .DEATH_TICKS(2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
   endtask

   task automatic act(input logic [1:0] id);
      bus.accion_valid = 1'b1;
      bus.accion_id    = id;
      cyc(1);
      bus.accion_valid = 1'b0;
      bus.accion_id    = 2'd0;
   endtask

   task automatic test_reset();
      // Reset must win over a concurrent action and test press.
      bus.accion_valid = 1'b1; bus.accion_id = 2'd0; bus.test = 1'b1;
      do_reset();
      bus.accion_valid = 1'b0; bus.test = 1'b0;
      total++; if (bus.niveles !== 9'h092) begin bad++; $display("FAIL reset_niveles got=%h exp=092", bus.niveles); end
      total++; if (bus.estado_actual !== 3'd0) begin bad++; $display("FAIL reset_estado got=%0d exp=0", bus.estado_actual); end
      total++; if (bus.estado_cambio !== 1'b0) begin bad++; $display("FAIL reset_cambio got=%b exp=0", bus.estado_cambio); end
      total++; if (bus.muerto !== 1'b0) begin bad++; $display("FAIL reset_muerto got=%b exp=0", bus.muerto); end
   endtask

   task automatic test_decay();
      int changes = 0;
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         cyc(1);
         if (bus.estado_cambio === 1'b1) changes++;
         if (k == 3) begin
            total++; if (bus.niveles !== 9'h092) begin bad++; $display("FAIL decay_pre_tick got=%h exp=092", bus.niveles); end
         end
         if (k == 4) begin
            total++; if (bus.niveles !== 9'h0DB) begin bad++; $display("FAIL decay_tick1 got=%h exp=0db", bus.niveles); end
         end
         if (k == 8) begin
            total++; if (bus.niveles !== 9'h124) begin bad++; $display("FAIL decay_tick2 got=%h exp=124", bus.niveles); end
            total++; if (bus.estado_actual !== 3'd0) begin bad++; $display("FAIL decay_estado_lag got=%0d exp=0", bus.estado_actual); end
         end
         if (k == 9) begin
            total++; if (bus.estado_actual !== 3'd4) begin bad++; $display("FAIL decay_hambriento got=%0d exp=4", bus.estado_actual); end
            total++; if (bus.estado_cambio !== 1'b1) begin bad++; $display("FAIL decay_cambio got=%b exp=1", bus.estado_cambio); end
         end
         if (k == 12) begin
            total++; if (bus.niveles !== 9'h16D) begin bad++; $display("FAIL decay_sat got=%h exp=16d", bus.niveles); end
            total++; if (bus.muerto !== 1'b0) begin bad++; $display("FAIL decay_not_dead got=%b exp=0", bus.muerto); end
         end
      end
      total++; if (changes != 1) begin bad++; $display("FAIL decay_pulse_count got=%0d exp=1", changes); end
   endtask

   // Continues from test_decay: levels at 5, death counter at 1 after edge 12.
   task automatic test_death();
      cyc(4);
      total++; if (bus.niveles !== 9'h16D) begin bad++; $display("FAIL death_levels_stay got=%h exp=16d", bus.niveles); end
      total++; if (bus.muerto !== 1'b1) begin bad++; $display("FAIL death_muerto got=%b exp=1", bus.muerto); end
      total++; if (bus.estado_actual !== 3'd4) begin bad++; $display("FAIL death_estado_lag got=%0d exp=4", bus.estado_actual); end
      cyc(1);
      total++; if (bus.estado_actual !== 3'd5) begin bad++; $display("FAIL death_estado got=%0d exp=5", bus.estado_actual); end
      total++; if (bus.estado_cambio !== 1'b1) begin bad++; $display("FAIL death_cambio got=%b exp=1", bus.estado_cambio); end
      act(2'd0);
      total++; if (bus.niveles !== 9'h16D) begin bad++; $display("FAIL death_action_ignored got=%h exp=16d", bus.niveles); end
      cyc(8);
      total++; if (bus.niveles !== 9'h16D) begin bad++; $display("FAIL death_frozen got=%h exp=16d", bus.niveles); end
      total++; if (bus.estado_actual !== 3'd5) begin bad++; $display("FAIL death_estado_hold got=%0d exp=5", bus.estado_actual); end
   endtask

   // Continues from test_death: dead pet, then test mode, then reset.
   task automatic test_reset_dead_test();
      bus.modo_test = 1'b1;
      bus.test = 1'b1; cyc(1); bus.test = 1'b0;
      total++; if (bus.estado_actual !== 3'd0) begin bad++; $display("FAIL deadtest_step got=%0d exp=0", bus.estado_actual); end
      total++; if (bus.muerto !== 1'b1) begin bad++; $display("FAIL deadtest_muerto_kept got=%b exp=1", bus.muerto); end
      cyc(1);
      bus.test = 1'b1; cyc(1);
      total++; if (bus.estado_actual !== 3'd1) begin bad++; $display("FAIL deadtest_step2 got=%0d exp=1", bus.estado_actual); end
      do_reset();
      bus.test = 1'b0; bus.modo_test = 1'b0;
      total++; if (bus.estado_actual !== 3'd0) begin bad++; $display("FAIL deadreset_estado got=%0d exp=0", bus.estado_actual); end
      total++; if (bus.muerto !== 1'b0) begin bad++; $display("FAIL deadreset_muerto got=%b exp=0", bus.muerto); end
      total++; if (bus.niveles !== 9'h092) begin bad++; $display("FAIL deadreset_niveles got=%h exp=092", bus.niveles); end
      total++; if (bus.estado_cambio !== 1'b0) begin bad++; $display("FAIL deadreset_cambio got=%b exp=0", bus.estado_cambio); end
   endtask

   task automatic test_action_floor();
      do_reset();
      cyc(3);
      act(2'd0);   // edge 4: tick and action, 2+1-2 = 1
      total++; if (bus.niveles !== 9'h0D9) begin bad++; $display("FAIL act_tick_collide got=%h exp=0d9", bus.niveles); end
      act(2'd0);   // edge 5: 1-2 floors at 0
      total++; if (bus.niveles !== 9'h0D8) begin bad++; $display("FAIL act_floor got=%h exp=0d8", bus.niveles); end
      act(2'd1);   // edge 6
      act(2'd2);   // edge 7
      total++; if (bus.niveles !== 9'h048) begin bad++; $display("FAIL act_relieve got=%h exp=048", bus.niveles); end
      cyc(1);      // edge 8
      total++; if (bus.niveles !== 9'h091) begin bad++; $display("FAIL act_after_tick got=%h exp=091", bus.niveles); end
      cyc(8);      // edge 16
      total++; if (bus.niveles !== 9'h123) begin bad++; $display("FAIL act_edge16 got=%h exp=123", bus.niveles); end
      cyc(1);      // edge 17: mood from {3,4,4}
      total++; if (bus.estado_actual !== 3'd3) begin bad++; $display("FAIL act_cansado got=%0d exp=3", bus.estado_actual); end
      cyc(2);
      act(2'd0);   // edge 20: tick and action on hambre = 3 -> 2
      total++; if (bus.niveles !== 9'h16A) begin bad++; $display("FAIL act_3plus1minus2 got=%h exp=16a", bus.niveles); end
      act(2'd3);   // edge 21: id out of range
      total++; if (bus.niveles !== 9'h16A) begin bad++; $display("FAIL act_bad_id got=%h exp=16a", bus.niveles); end
      total++; if (bus.muerto !== 1'b0) begin bad++; $display("FAIL act_alive got=%b exp=0", bus.muerto); end
   endtask

   task automatic test_priority();
      do_reset();
      cyc(9);      // levels {4,4,4} at edge 8, mood at edge 9
      total++; if (bus.estado_actual !== 3'd4) begin bad++; $display("FAIL prio_hambriento got=%0d exp=4", bus.estado_actual); end
      act(2'd0);   // edge 10 -> {2,4,4}
      act(2'd2);   // edge 11 -> {2,4,2}, mood from {2,4,4}
      total++; if (bus.estado_actual !== 3'd3) begin bad++; $display("FAIL prio_cansado got=%0d exp=3", bus.estado_actual); end
      act(2'd1);   // edge 12 tick -> {3,3,3}, mood from {2,4,2}
      total++; if (bus.estado_actual !== 3'd2) begin bad++; $display("FAIL prio_triste got=%0d exp=2", bus.estado_actual); end
      total++; if (bus.niveles !== 9'h0DB) begin bad++; $display("FAIL prio_levels12 got=%h exp=0db", bus.niveles); end
      act(2'd0);   // edge 13
      act(2'd1);   // edge 14
      act(2'd2);   // edge 15 -> {1,1,1}
      total++; if (bus.niveles !== 9'h049) begin bad++; $display("FAIL prio_all_low got=%h exp=049", bus.niveles); end
      cyc(1);      // edge 16
      total++; if (bus.estado_actual !== 3'd1) begin bad++; $display("FAIL prio_feliz got=%0d exp=1", bus.estado_actual); end
      total++; if (bus.estado_cambio !== 1'b1) begin bad++; $display("FAIL prio_feliz_cambio got=%b exp=1", bus.estado_cambio); end
   endtask

   task automatic test_test_mode();
      int changes = 0;
      logic [2:0] exp_st;
      do_reset();
      cyc(2);      // prescaler parked at 2
      bus.modo_test = 1'b1;
      cyc(1);
      total++; if (bus.estado_actual !== 3'd0) begin bad++; $display("FAIL tm_enter_hold got=%0d exp=0", bus.estado_actual); end
      for (int p = 0; p < 6; p++) begin
         exp_st = (p == 5) ? 3'd0 : 3'(p + 1);
         bus.test = 1'b1;
         for (int h = 0; h < ((p == 0) ? 10 : 2); h++) begin
            cyc(1);
            if (bus.estado_cambio === 1'b1) changes++;
         end
         total++; if (bus.estado_actual !== exp_st) begin bad++; $display("FAIL tm_step%0d got=%0d exp=%0d", p, bus.estado_actual, exp_st); end
         if (p == 4) begin
            total++; if (bus.muerto !== 1'b0) begin bad++; $display("FAIL tm_muerto_display got=%b exp=0", bus.muerto); end
         end
         bus.test = 1'b0;
         for (int h = 0; h < 2; h++) begin
            cyc(1);
            if (bus.estado_cambio === 1'b1) changes++;
         end
      end
      total++; if (changes != 6) begin bad++; $display("FAIL tm_step_count got=%0d exp=6", changes); end
      total++; if (bus.niveles !== 9'h092) begin bad++; $display("FAIL tm_levels_frozen got=%h exp=092", bus.niveles); end
      bus.test = 1'b1; cyc(1); bus.test = 1'b0;
      total++; if (bus.estado_actual !== 3'd1) begin bad++; $display("FAIL tm_extra_step got=%0d exp=1", bus.estado_actual); end
      cyc(1);
      bus.modo_test = 1'b0;
      cyc(1);      // back to computed mood; prescaler 2 -> 3
      total++; if (bus.estado_actual !== 3'd0) begin bad++; $display("FAIL tm_exit_mood got=%0d exp=0", bus.estado_actual); end
      total++; if (bus.estado_cambio !== 1'b1) begin bad++; $display("FAIL tm_exit_cambio got=%b exp=1", bus.estado_cambio); end
      total++; if (bus.niveles !== 9'h092) begin bad++; $display("FAIL tm_exit_levels got=%h exp=092", bus.niveles); end
      cyc(1);      // prescaler resumed from 3 and ticks now
      total++; if (bus.niveles !== 9'h0DB) begin bad++; $display("FAIL tm_prescaler_resume got=%h exp=0db", bus.niveles); end
   endtask

   initial begin
      reset            = 1'b1;
      bus.accion_valid = 1'b0;
      bus.accion_id    = 2'd0;
      bus.modo_test    = 1'b0;
      bus.test         = 1'b0;
      @(negedge clk);
      test_reset();
      test_decay();
      test_death();
      test_reset_dead_test();
      test_action_floor();
      test_priority();
      test_test_mode();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
